// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - multi-channel programmable clock divider with period-aligned updates
module clock_divider_prog #(
    parameter int CH      = 4,
    parameter int W       = 8,
    parameter int DEF_DIV = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH-1:0]   en,
    input  logic            sync,
    input  logic [CH-1:0]   div_load,
    input  logic [CH*W-1:0] div_in,
    output logic [CH-1:0]   clk_out,
    output logic [CH-1:0]   tick,
    output logic [CH-1:0]   pending
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);
    localparam logic [W-1:0] ONE_W     = W'(1);
    localparam logic [W-1:0] ZERO_W    = '0;

    for (genvar c = 0; c < CH; c++) begin : g_ch

        state_t       state;
        state_t       state_nxt;
        logic [W-1:0] phase;
        logic [W-1:0] phase_nxt;
        logic [W-1:0] active;
        logic [W-1:0] active_nxt;
        logic [W-1:0] shadow;
        logic [W-1:0] shadow_nxt;
        logic         pending_q;
        logic         pending_nxt;
        logic         clk_out_q;
        logic         tick_q;

        logic [W-1:0] load_val;
        logic [W-1:0] apply_div;
        logic [W-1:0] high_len;
        logic         at_boundary;
        logic         restart;
        logic         clk_out_nxt;
        logic         tick_nxt;

        // Next-state decision: period restarts, idle start-up and shadow capture
        always_comb begin
            load_val    = div_in[c*W +: W];
            apply_div   = pending_q ? shadow : active;
            at_boundary = (state == ST_RUN) && (phase == active - ONE_W);
            restart     = (state == ST_RUN) && (at_boundary || sync);

            state_nxt   = state;
            phase_nxt   = phase;
            active_nxt  = active;
            shadow_nxt  = shadow;
            pending_nxt = pending_q;

            if (state == ST_IDLE) begin
                if (en[c] && (apply_div != ZERO_W)) begin
                    // Start a fresh period with whatever divisor is current
                    active_nxt  = apply_div;
                    pending_nxt = 1'b0;
                    state_nxt   = ST_RUN;
                    phase_nxt   = ZERO_W;
                end else if (pending_q && (shadow == ZERO_W)) begin
                    // A zero divisor parks the channel; apply it immediately
                    active_nxt  = shadow;
                    pending_nxt = 1'b0;
                end
            end else begin
                if (restart) begin
                    // Period boundary or sync: swap in the shadow, then decide run/stop
                    active_nxt  = apply_div;
                    pending_nxt = 1'b0;
                    phase_nxt   = ZERO_W;
                    if (en[c] && (apply_div != ZERO_W)) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    phase_nxt = phase + ONE_W;
                end
            end

            // A load in the same cycle as a boundary lands after the swap,
            // so the boundary uses the previous shadow and this one waits.
            if (div_load[c]) begin
                shadow_nxt  = load_val;
                pending_nxt = 1'b1;
            end

            // High portion is ceil(N/2) cycles; N=1 gives a constant high
            high_len    = active_nxt - (active_nxt >> 1);
            clk_out_nxt = (state_nxt == ST_RUN) && (phase_nxt < high_len);
            tick_nxt    = (state_nxt == ST_RUN) && (phase_nxt == ZERO_W);
        end

        // Channel state and registered outputs decoded from the upcoming state/phase
        always_ff @(posedge clk) begin
            if (reset) begin
                state     <= ST_IDLE;
                phase     <= ZERO_W;
                active    <= DEF_DIV_W;
                shadow    <= DEF_DIV_W;
                pending_q <= 1'b0;
                clk_out_q <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                state     <= state_nxt;
                phase     <= phase_nxt;
                active    <= active_nxt;
                shadow    <= shadow_nxt;
                pending_q <= pending_nxt;
                clk_out_q <= clk_out_nxt;
                tick_q    <= tick_nxt;
            end
        end

        assign clk_out[c] = clk_out_q;
        assign tick[c]    = tick_q;
        assign pending[c] = pending_q;
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - self-checking bench for clock_divider_prog
module tb_clock_divider_prog;

    localparam int CH      = 4;
    localparam int W       = 8;
    localparam int DEF_DIV = 2;

    logic            clk;
    logic            reset;
    logic [CH-1:0]   en;
    logic            sync;
    logic [CH-1:0]   div_load;
    logic [CH*W-1:0] div_in;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   pending;

    int checks = 0;
    int errors = 0;

    clock_divider_prog #(
        .CH(CH),
        .W(W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .sync(sync),
        .div_load(div_load),
        .div_in(div_in),
        .clk_out(clk_out),
        .tick(tick),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each running channel holds a queue of the remaining
    // {clk_out, tick} samples of its current period; the front is this cycle.
    logic [1:0] mq [CH][$];
    int         m_active [CH];
    int         m_shadow [CH];
    bit         m_pend   [CH];

    task automatic push_period(input int c, input int n);
        for (int k = 0; k < n; k++) begin
            mq[c].push_back({(k < (n + 1) / 2) ? 1'b1 : 1'b0, (k == 0) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic model_step(input logic rst, input logic [CH-1:0] e, input logic s,
                              input logic [CH-1:0] ld, input logic [CH*W-1:0] din);
        for (int c = 0; c < CH; c++) begin
            int use_n;
            if (rst) begin
                mq[c].delete();
                m_active[c] = DEF_DIV;
                m_shadow[c] = DEF_DIV;
                m_pend[c]   = 1'b0;
                continue;
            end
            use_n = m_pend[c] ? m_shadow[c] : m_active[c];
            if (mq[c].size() != 0) begin
                if (mq[c].size() == 1 || s) begin
                    m_active[c] = use_n;
                    m_pend[c]   = 1'b0;
                    mq[c].delete();
                    if (e[c] && use_n != 0) push_period(c, use_n);
                end else begin
                    void'(mq[c].pop_front());
                end
            end else begin
                if (e[c] && use_n != 0) begin
                    m_active[c] = use_n;
                    m_pend[c]   = 1'b0;
                    push_period(c, use_n);
                end else if (m_pend[c] && m_shadow[c] == 0) begin
                    m_active[c] = 0;
                    m_pend[c]   = 1'b0;
                end
            end
            if (ld[c]) begin
                m_shadow[c] = int'(din[c*W +: W]);
                m_pend[c]   = 1'b1;
            end
        end
    endtask

    task automatic check_vec(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [CH-1:0] e_clk;
        logic [CH-1:0] e_tick;
        logic [CH-1:0] e_pend;
        for (int c = 0; c < CH; c++) begin
            e_clk[c]  = (mq[c].size() != 0) ? mq[c][0][1] : 1'b0;
            e_tick[c] = (mq[c].size() != 0) ? mq[c][0][0] : 1'b0;
            e_pend[c] = m_pend[c];
        end
        check_vec({tag, " clk_out"}, clk_out, e_clk);
        check_vec({tag, " tick"}, tick, e_tick);
        check_vec({tag, " pending"}, pending, e_pend);
    endtask

    // One clock: DUT and model both consume the inputs present at the edge
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step(reset, en, sync, div_load, div_in);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1; en = '0; sync = 1'b0; div_load = '0; div_in = '0;
        cycle("reset");
        reset = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic [CH-1:0] en;
        logic          sync;
        logic [CH-1:0] ld;
        logic [CH*W-1:0] din;
        logic [CH-1:0] exp_clk;
        logic [CH-1:0] exp_tick;
        logic [CH-1:0] exp_pend;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [7:0] rec;

        reset = 1'b1; en = '0; sync = 1'b0; div_load = '0; div_in = '0;

        // rst, en, sync, ld, din, exp clk_out, exp tick, exp pending
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 32'h0,   4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 32'h0,   4'b0001, 4'b0001, 4'b0000};
        vecs[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 32'h0,   4'b0000, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 32'h0,   4'b0001, 4'b0001, 4'b0000};
        vecs[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 32'h0,   4'b0000, 4'b0000, 4'b0000};
        vecs[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0010, 32'h300, 4'b0001, 4'b0001, 4'b0010};
        vecs[6]  = '{1'b0, 4'b0011, 1'b0, 4'b0000, 32'h0,   4'b0010, 4'b0010, 4'b0000};
        vecs[7]  = '{1'b0, 4'b0011, 1'b0, 4'b0000, 32'h0,   4'b0011, 4'b0001, 4'b0000};
        vecs[8]  = '{1'b0, 4'b0011, 1'b0, 4'b0000, 32'h0,   4'b0000, 4'b0000, 4'b0000};
        vecs[9]  = '{1'b0, 4'b0011, 1'b0, 4'b0000, 32'h0,   4'b0011, 4'b0011, 4'b0000};
        vecs[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 32'h0,   4'b0010, 4'b0000, 4'b0000};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 32'h0,   4'b0000, 4'b0000, 4'b0000};
        vecs[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 32'h0,   4'b0000, 4'b0000, 4'b0000};
        vecs[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 32'h0,   4'b0000, 4'b0000, 4'b0000};

        for (int i = 0; i < 14; i++) begin
            reset = vecs[i].rst; en = vecs[i].en; sync = vecs[i].sync;
            div_load = vecs[i].ld; div_in = vecs[i].din;
            @(posedge clk);
            model_step(reset, en, sync, div_load, div_in);
            #1;
            check_vec($sformatf("vec%0d clk_out", i), clk_out, vecs[i].exp_clk);
            check_vec($sformatf("vec%0d tick", i), tick, vecs[i].exp_tick);
            check_vec($sformatf("vec%0d pending", i), pending, vecs[i].exp_pend);
        end

        // Divisor change mid-period: N=4 period completes, then N=6
        do_reset();
        div_load = 4'b0001; div_in = 32'h4;
        cycle("ld4");
        div_load = '0; en = 4'b0001;
        cycle("start4");
        check_val("start4 tick0", int'(tick[0]), 1);
        cycle("n4 ph1");
        div_load = 4'b0001; div_in = 32'h6;
        cycle("ld6");
        div_load = '0;
        check_val("ld6 pending0", int'(pending[0]), 1);
        check_val("ld6 clk0", int'(clk_out[0]), 0);
        for (int i = 0; i < 8; i++) begin
            cycle("n4to6");
            rec[i] = clk_out[0];
        end
        check_vec("n4to6 pattern", rec[3:0], 4'b1110);
        check_vec("n4to6 pattern hi", rec[7:4], 4'b1000);
        check_val("n4to6 pending0", int'(pending[0]), 0);

        // en glitch inside an N=5 period, then en held low
        div_load = 4'b0001; div_in = 32'h5;
        for (int i = 0; i < 8; i++) begin
            cycle("n5 load");
            div_load = '0;
        end
        en = 4'b0000;
        cycle("en glitch");
        en = 4'b0001;
        for (int i = 0; i < 6; i++) cycle("n5 run");
        en = 4'b0000;
        for (int i = 0; i < 7; i++) cycle("n5 stop");
        check_val("n5 stop clk0", int'(clk_out[0]), 0);
        check_val("n5 stop tick0", int'(tick[0]), 0);

        // sync realigns N=4 and N=6 channels running out of phase
        do_reset();
        div_load = 4'b0011; div_in = 32'h0604;
        cycle("ld sync");
        div_load = '0; en = 4'b0001;
        cycle("start ch0");
        en = 4'b0011;
        for (int i = 0; i < 3; i++) cycle("pre sync");
        sync = 1'b1;
        cycle("sync");
        sync = 1'b0;
        check_vec("sync tick", tick[1:0], 2'b11);
        for (int i = 0; i < 4; i++) cycle("post sync");
        check_vec("post sync tick", tick[1:0], 2'b01);

        // N=1 then N=0 on channel 2
        do_reset();
        div_load = 4'b0100; div_in = 32'h0001_0000;
        cycle("ld1");
        div_load = '0; en = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            cycle("n1");
            check_val("n1 tick2", int'(tick[2]), 1);
            check_val("n1 clk2", int'(clk_out[2]), 1);
        end
        div_load = 4'b0100; div_in = 32'h0;
        cycle("ld0");
        div_load = '0;
        check_val("ld0 pending2", int'(pending[2]), 1);
        cycle("n0 idle");
        check_val("n0 clk2", int'(clk_out[2]), 0);
        check_val("n0 tick2", int'(tick[2]), 0);
        cycle("n0 stays idle");
        check_val("n0 still idle", int'(tick[2]), 0);

        // Reset mid-period restores defaults
        div_load = 4'b0001; div_in = 32'h5;
        cycle("ld5 rst");
        div_load = '0; en = 4'b0001;
        for (int i = 0; i < 3; i++) cycle("n5 pre rst");
        reset = 1'b1;
        cycle("mid reset");
        check_val("mid reset outputs", int'({clk_out, tick, pending}), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle("after rst");
            rec[i] = clk_out[0];
        end
        check_vec("after rst def div", rec[3:0], 4'b0101);

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 499) == 0);
            sync  = ($urandom_range(0, 15) == 0);
            for (int c = 0; c < CH; c++) begin
                en[c]       = ($urandom_range(0, 9) != 0);
                div_load[c] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 7) == 0) div_in[c*W +: W] = W'($urandom_range(0, 255));
                else                           div_in[c*W +: W] = W'($urandom_range(0, 7));
            end
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
